// File: rtl/fetch_stage_pq.sv
// Decoupled RV32 instruction-fetch stage.
// Requests go to instruction memory under a credit limit. In-order responses
// land in a small prefetch queue, and the queue head feeds the IF/ID register.
// A redirect from MEM flushes the queue and discards every response that is
// still in flight.
module fetch_stage_pq #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stallD,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] InstrD,
  output logic            validD
);

  localparam int unsigned     PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned     CW  = PW + 1;
  localparam int unsigned     OW  = CW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // One prefetch queue entry: the fetch address and the word returned for it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q,   rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [XLEN-1:0] pcd_q,      pcd_d;
  logic [XLEN-1:0] instrd_q,   instrd_d;
  logic            validd_q,   validd_d;

  entry_t          q_mem_q [FIFO_DEPTH];
  entry_t          head;
  entry_t          push_entry;

  logic [OW-1:0]   occupancy;
  logic            issue;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target_pc;

  // Credit check plus handshake, push and pop qualifiers.
  // The queue cannot overflow because a request needs a free slot for its response.
  always_comb begin
    occupancy      = {1'b0, inflight_q} + {1'b0, count_q};
    imem_req_valid = !reset && !redirect_valid && (occupancy < OW'(FIFO_DEPTH));
    imem_req_addr  = fetch_pc_q;
    issue          = imem_req_valid && imem_req_ready;
    push           = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
    pop            = !redirect_valid && !stallD && (count_q != '0);
    head           = q_mem_q[rd_ptr_q];
    push_entry     = '{pc: rsp_pc_q, instr: imem_rsp_data};
    target_pc      = {redirect_pc[XLEN-1:2], 2'b00};
  end

  // Next-state logic. A redirect takes priority over stall, issue, push and pop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pcd_d      = pcd_q;
    instrd_d   = instrd_q;
    validd_d   = validd_q;

    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      // No request issues this cycle. Every request still outstanding after
      // this edge is stale, and a response returning this edge is dropped too.
      inflight_d = inflight_q - CW'(imem_rsp_valid);
      drop_cnt_d = inflight_q - CW'(imem_rsp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      validd_d   = 1'b0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      inflight_d = inflight_q + CW'(issue) - CW'(imem_rsp_valid);

      if (imem_rsp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          rsp_pc_d = rsp_pc_q + PC_STEP;
        end
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      // Decode register: with no stall, take the queue head or insert a bubble.
      // An entry pushed this edge is not visible until the next edge.
      if (!stallD) begin
        if (count_q != '0) begin
          pcd_d    = head.pc;
          instrd_d = head.instr;
          validd_d = 1'b1;
        end else begin
          validd_d = 1'b0;
        end
      end
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pcd_q      <= '0;
      instrd_q   <= NOP;
      validd_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pcd_q      <= pcd_d;
      instrd_q   <= instrd_d;
      validd_q   <= validd_d;
    end
  end

  // Queue storage. Occupancy is tracked by count_q, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // A push into a full queue with no pop would mean the credit rule is broken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && (count_q == CW'(FIFO_DEPTH))));
    end
  end

  assign PCD    = pcd_q;
  assign InstrD = instrd_q;
  assign validD = validd_q;

endmodule

// File: doc/fetch_stage_pq.md
Name: fetch_stage_pq

Overview:
- Parametrised pipelined instruction-fetch stage for the RV32 core. Generalises the single-cycle fetch into a decoupled fetch:
  - request/response handshake to instruction memory with variable latency;
  - prefetch queue of depth FIFO_DEPTH;
  - decode-stage stall;
  - redirect/flush from the memory stage (taken branch or jump).
- Feeds the IF/ID register outputs PCD/InstrD/validD directly.

Parameters:
- XLEN, 32, address/instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch queue entries; power of two, ≥2. Also the maximum of in-flight plus queued instructions.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  taken branch or jump resolved in MEM (BranchM|JtypeM qualified).
- redirect_pc  in  XLEN  target: PCPlusImmM or ALUOutM, selected upstream.
- stallD  in  1  decode cannot accept; hold PCD/InstrD/validD.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; in order, always accepted (no ready).
- imem_rsp_data  in  XLEN  instruction word.
- PCD  out  XLEN  PC of instruction in decode.
- InstrD  out  XLEN  instruction in decode.
- validD  out  1  PCD/InstrD hold a real instruction; 0 = bubble.

Behaviour:
- Reset (async): fetch_pc=RESET_PC, rsp_pc=RESET_PC, inflight=0, drop_cnt=0, queue empty, PCD=0, InstrD=32'h0000_0013 (NOP), validD=0, imem_req_valid=0. Instruction memory shares the same reset, so no stale responses arrive after release.
- Request issue:
  - imem_req_valid=1 when not reset, !redirect_valid, and inflight+count < FIFO_DEPTH.
  - imem_req_addr = fetch_pc.
  - Handshake (valid&ready at edge): fetch_pc += 4 (mod 2^XLEN), inflight++.
- Response:
  - On imem_rsp_valid, inflight--.
  - If drop_cnt>0: response discarded, drop_cnt--.
  - Otherwise push {rsp_pc, imem_rsp_data} into the queue; rsp_pc += 4.
  - The credit rule guarantees the queue never overflows. Overflow is an assertion failure.
- Decode register:
  - At each edge with !stallD: if queue non-empty, pop the head into PCD/InstrD and set validD=1. If empty, validD=0 and PCD/InstrD hold.
  - stallD=1: all three hold; no pop.
- Latency: response accepted at edge E reaches decode at edge E+1 (no same-cycle bypass). With 1-cycle memory, the first instruction after reset is validD=1 three edges after reset release.
- Throughput: 1 instr/cycle sustained when memory latency < FIFO_DEPTH.
- Redirect (redirect_valid=1 at edge), highest priority:
  - fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - Queue flushed; validD=0 regardless of stallD.
  - drop_cnt = inflight minus the response returning this edge; the returning response is dropped.
  - No request issues in the redirect cycle.
- Simultaneous events:
  - issue+response same edge: inflight unchanged.
  - push+pop same edge on a full queue: legal.
  - redirect overrides stall, issue, push and pop.
- Wrap: PC 32'hFFFF_FFFC + 4 → 32'h0000_0000; no flag.
- Reset mid-operation: async clear of all state within the same cycle; outputs return to reset values immediately.

Test Plan:
1. Reset, 1-cycle memory returning addr^32'hA5A5_0000, stallD=0 → PCD sequence 0,4,8,C with validD=1 from the third edge after release, one per cycle; imem_req_addr never repeats.
2. stallD=1 for 5 cycles mid-stream → PCD/InstrD frozen; at most FIFO_DEPTH=4 requests accepted beyond the held instruction; on release, consecutive PCs with no gaps or duplicates.
3. Memory latency 3 cycles, 3 requests in flight, redirect_valid=1 with redirect_pc=32'h0000_0102 → validD=0 next cycle; 3 stale responses dropped; next issued addr 32'h0000_0100; PCD=0x100 is the first valid instruction.
4. Redirect in the same cycle as stallD=1 and imem_rsp_valid=1 → response dropped, validD=0, queue empty, fetch resumes at target.
5. redirect_pc=32'hFFFF_FFF8 → PCD sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
6. Assert reset while 2 requests are in flight and the queue is full → PCD=0, InstrD=0x13, validD=0, imem_req_valid=0 immediately; after release, fetch restarts at RESET_PC.
